ex_muldiv: RTL and testbench

//  Multi-cycle multiply/divide unit for step_ex, parametrised in WIDTH.

---
 rtl/ex_muldiv_if.sv | 14 +
 rtl/ex_muldiv.sv | 92 +++++++++
 tb/tb_ex_muldiv.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage handshake and HI/LO result bus for the mul/div unit
interface ex_muldiv_if #(parameter int WIDTH = 32);
  logic               start;
  logic [2:0]         op;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [2*WIDTH-1:0] hilo_in;
  logic               flush;
  logic               busy;
  logic [2*WIDTH-1:0] hilo_o;
  logic               we_hilo;
  modport master(output start, op, src_a, src_b, hilo_in, flush, input busy, hilo_o, we_hilo);
  modport slave(input start, op, src_a, src_b, hilo_in, flush, output busy, hilo_o, we_hilo);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/DIV/MADD/MSUB unit producing a new HI/LO pair and write strobe
module ex_muldiv #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2,
  parameter int ENABLE_MADD = 1
) (
  input logic       clk,
  input logic       rst_n,
  ex_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + MUL_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t             state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, rem, quo;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt;
  logic               sgn, a_neg, b_neg, is_div;
  logic [WIDTH-1:0]   in_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]     r_sh, diff;
  logic [2*WIDTH-1:0] prod, mul_res;
  always_comb begin
    sgn     = ~op_q[0];
    a_neg   = sgn & a_q[WIDTH-1];
    b_neg   = sgn & b_q[WIDTH-1];
    b_mag   = b_neg ? -b_q : b_q;
    is_div  = bus.op[2:1] == 2'b01;
    in_mag  = (~bus.op[0] & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
    prod    = {{WIDTH{a_neg}}, a_q} * {{WIDTH{b_neg}}, b_q};
    mul_res = (ENABLE_MADD != 0 && op_q[2]) ? (op_q[1] ? acc_q - prod : acc_q + prod) : prod;
    r_sh    = {rem, quo[WIDTH-1]};
    diff    = r_sh - {1'b0, b_mag};
    q_fix   = (a_neg ^ b_neg) ? -quo : quo;
    r_fix   = a_neg ? -rem : rem;
  end
  assign bus.busy = (state == IDLE && bus.start && !bus.flush) || state inside {MUL, DIV, FIX};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      rem         <= '0;
      quo         <= '0;
      cnt         <= '0;
      bus.hilo_o  <= '0;
      bus.we_hilo <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      bus.we_hilo <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op_q  <= bus.op;
          a_q   <= bus.src_a;
          b_q   <= bus.src_b;
          acc_q <= bus.hilo_in;
          rem   <= '0;
          quo   <= in_mag;
          cnt   <= is_div ? CW'(WIDTH - 1) : CW'(MUL_LATENCY - 1);
          state <= is_div ? DIV : MUL;
        end
        MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            bus.hilo_o  <= mul_res;
            bus.we_hilo <= 1'b1;
            state       <= DONE;
          end
        end
        // restoring step: keep the trial difference only when it did not borrow
        DIV: begin
          quo   <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          rem   <= diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? FIX : DIV;
        end
        FIX: begin
          bus.hilo_o  <= b_q == '0 ? {a_q, {WIDTH{1'b1}}} : {r_fix, q_fix};
          bus.we_hilo <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          bus.we_hilo <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of latency, results, flush, reset and strobe behaviour
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ex_muldiv_if #(.WIDTH(32)) bus();
  ex_muldiv #(.WIDTH(32), .MUL_LATENCY(2), .ENABLE_MADD(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  int lat, bcnt, pulses;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start held through DONE; operands scrambled after accept to prove latching
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] h);
    bus.op = o; bus.src_a = a; bus.src_b = b; bus.hilo_in = h; bus.start = 1'b1;
    lat = -1; bcnt = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.we_hilo) begin
        lat = c;
        break;
      end
      if (bus.busy) bcnt++;
      tick();
      if (c == 0) begin
        bus.src_a = ~a; bus.src_b = ~b; bus.hilo_in = ~h; bus.op = ~o;
      end
    end
  endtask

  task automatic res(input string tag, input int le, input logic [63:0] he);
    chk({tag, "_lat"}, lat, le);
    chk({tag, "_busycyc"}, bcnt, le);
    chk({tag, "_hilo"}, bus.hilo_o, he);
    chk({tag, "_busy_done"}, bus.busy, 1'b0);
    tick();
    bus.start = 1'b0;
    #1;
    chk({tag, "_we_off"}, bus.we_hilo, 1'b0);
    chk({tag, "_held"}, bus.hilo_o, he);
  endtask

  initial begin
    bus.start = 0; bus.flush = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0; bus.hilo_in = 0;
    tick(); tick();
    chk("rst_hilo", bus.hilo_o, 64'h0);
    chk("rst_we", bus.we_hilo, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    run(3'd0, 32'hFFFFFFFD, 32'd5, 64'h0);
    res("mult", 3, 64'hFFFFFFFF_FFFFFFF1);
    run(3'd3, 32'd100, 32'd7, 64'h0);
    res("divu", 34, {32'd2, 32'd14});
    run(3'd2, 32'hFFFFFFF9, 32'd2, 64'h0);
    res("div_neg", 34, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h0);
    res("div_ovf", 34, {32'h0, 32'h80000000});
    run(3'd3, 32'd5, 32'd0, 64'h0);
    res("divu_zero", 34, {32'd5, 32'hFFFFFFFF});
    run(3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1);
    res("maddu", 3, 64'hFFFFFFFE_00000002);
    run(3'd6, 32'd2, 32'd3, 64'h0);
    res("msub", 3, 64'hFFFFFFFF_FFFFFFFA);
    // flush a DIVU in cycle 10
    bus.op = 3'd3; bus.src_a = 32'd1000; bus.src_b = 32'd3; bus.start = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.we_hilo) pulses++;
      tick();
    end
    bus.flush = 1'b1; bus.start = 1'b0;
    #1;
    if (bus.we_hilo) pulses++;
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_busy", bus.busy, 1'b0);
    chk("flush_pulses", pulses, 0);
    chk("flush_we", bus.we_hilo, 1'b0);
    chk("flush_hilo", bus.hilo_o, 64'hFFFFFFFF_FFFFFFFA);
    run(3'd1, 32'd3, 32'd4, 64'h0);
    res("multu_after_flush", 3, 64'd12);
    // reset in cycle 5 of a DIVU
    bus.op = 3'd3; bus.src_a = 32'd50; bus.src_b = 32'd7; bus.start = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0; bus.start = 1'b0;
    #1;
    chk("midrst_hilo", bus.hilo_o, 64'h0);
    chk("midrst_we", bus.we_hilo, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    run(3'd0, 32'd2, 32'd3, 64'h0);
    res("mult_after_rst", 3, 64'd6);
    // start held into DONE gives a single strobe
    run(3'd1, 32'd7, 32'd6, 64'h0);
    res("hold", 3, 64'd42);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.we_hilo) pulses++;
      tick();
    end
    chk("hold_pulses", pulses, 0);
    chk("hold_busy", bus.busy, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
